// File: rtl/cram_sequencer.sv
// Microcode address sequencer for the control RAM: next-address selection,
// dispatch/skip OR modifiers, forced trap entry and the call/return stack.
module cram_sequencer #(
    parameter int              ADR_W       = 11,
    parameter int              STACK_DEPTH = 16,
    parameter logic [ADR_W-1:0] FORCE_ADR  = 11'o1777
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           advance,
    input  logic [ADR_W-1:0]               jIn,
    input  logic                           skipEn,
    input  logic                           skipTrue,
    input  logic                           dispEn,
    input  logic [3:0]                     dispIn,
    input  logic                           dramEn,
    input  logic [ADR_W-1:0]               dramJ,
    input  logic                           call,
    input  logic                           ret,
    input  logic                           force1777,
    output logic [ADR_W-1:0]               crAdr,
    output logic [$clog2(STACK_DEPTH):0]   stackDepth,
    output logic [ADR_W-1:0]               stackTop,
    output logic                           stackErr,
    output logic                           trapTaken
);

    localparam int PTR_W   = $clog2(STACK_DEPTH);
    localparam int DEPTH_W = PTR_W + 1;
    localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(STACK_DEPTH);

    // Dispatch and skip modifiers are pure ORs: no carry ever propagates.
    function automatic logic [ADR_W-1:0] apply_mods(
        input logic [ADR_W-1:0] base,
        input logic             disp_en,
        input logic [3:0]       disp_bits,
        input logic             skip
    );
        logic [ADR_W-1:0] m;
        m = '0;
        if (disp_en) m[3:0] = disp_bits;
        m[0] = m[0] | skip;
        return base | m;
    endfunction

    logic [ADR_W-1:0]   stack_mem [STACK_DEPTH];
    logic [DEPTH_W-1:0] depth_m1;
    logic [DEPTH_W-1:0] depth_mid;
    logic [DEPTH_W-1:0] depth_nxt;
    logic [ADR_W-1:0]   popped;
    logic [ADR_W-1:0]   adr_nxt;
    logic               do_pop;
    logic               do_push;
    logic               push_ok;
    logic               err_evt;

    assign depth_m1 = stackDepth - DEPTH_W'(1);
    assign stackTop = (stackDepth == '0) ? '0 : stack_mem[depth_m1[PTR_W-1:0]];

    always_comb begin
        do_pop    = ret & ~force1777;
        do_push   = call | force1777;
        popped    = '0;
        depth_mid = stackDepth;
        err_evt   = 1'b0;
        if (do_pop) begin
            if (stackDepth == '0) begin
                err_evt = 1'b1;
            end else begin
                popped    = stackTop;
                depth_mid = depth_m1;
            end
        end
        // Pop happens before push, so call+ret on a full stack replaces the top.
        push_ok   = do_push && (depth_mid != FULL);
        depth_nxt = depth_mid;
        if (do_push) begin
            if (push_ok) depth_nxt = depth_mid + DEPTH_W'(1);
            else         err_evt   = 1'b1;
        end
        if (force1777)   adr_nxt = FORCE_ADR;
        else if (ret)    adr_nxt = popped | jIn;
        else if (dramEn) adr_nxt = apply_mods(dramJ, dispEn, dispIn, skipEn & skipTrue);
        else             adr_nxt = apply_mods(jIn, dispEn, dispIn, skipEn & skipTrue);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crAdr      <= '0;
            stackDepth <= '0;
            stackErr   <= 1'b0;
            trapTaken  <= 1'b0;
        end else begin
            trapTaken <= advance & force1777;
            if (advance) begin
                crAdr      <= adr_nxt;
                stackDepth <= depth_nxt;
                if (err_evt) stackErr <= 1'b1;
            end
        end
    end

    // Stack storage carries no reset; only entries below stackDepth are meaningful.
    always_ff @(posedge clk) begin
        if (!reset && advance && push_ok)
            stack_mem[depth_mid[PTR_W-1:0]] <= crAdr;
    end

endmodule

// File: tb/tb_cram_sequencer.sv
// Directed bench for cram_sequencer with hand-computed expected addresses.
module tb_cram_sequencer;

    logic        clk = 1'b0;
    logic        reset, advance, skipEn, skipTrue, dispEn, dramEn;
    logic        call, ret, force1777;
    logic [3:0]  dispIn;
    logic [10:0] jIn, dramJ;
    logic [10:0] crAdr, stackTop;
    logic [4:0]  stackDepth;
    logic        stackErr, trapTaken;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cram_sequencer dut (
        .clk(clk), .reset(reset), .advance(advance), .jIn(jIn),
        .skipEn(skipEn), .skipTrue(skipTrue), .dispEn(dispEn), .dispIn(dispIn),
        .dramEn(dramEn), .dramJ(dramJ), .call(call), .ret(ret),
        .force1777(force1777), .crAdr(crAdr), .stackDepth(stackDepth),
        .stackTop(stackTop), .stackErr(stackErr), .trapTaken(trapTaken)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        skipEn = 0; skipTrue = 0; dispEn = 0; dispIn = 0; dramEn = 0; dramJ = 0;
        call = 0; ret = 0; force1777 = 0;
    endtask

    initial begin
        reset = 1; advance = 1; jIn = 11'o0123;
        clr();
        step(); step();
        chk("rst_adr", crAdr, 0);
        chk("rst_depth", stackDepth, 0);
        chk("rst_top", stackTop, 0);
        chk("rst_err", stackErr, 0);
        chk("rst_trap", trapTaken, 0);
        reset = 0;
        step();
        chk("rel_adr", crAdr, 11'o0123);
        chk("rel_depth", stackDepth, 0);
        chk("rel_err", stackErr, 0);

        jIn = 11'o0200; dispEn = 1; dispIn = 4'b0101; skipEn = 1; skipTrue = 1;
        step(); chk("disp_skip", crAdr, 11'o0205);
        skipTrue = 0;
        step(); chk("disp_noskip", crAdr, 11'o0205);
        dispIn = 4'b0100;
        step(); chk("disp_0100", crAdr, 11'o0204);
        dramEn = 1; dramJ = 11'o1230; dispIn = 4'b0011; skipTrue = 1;
        step(); chk("dram_mods", crAdr, 11'o1233);
        clr();

        jIn = 11'o0400;
        step(); chk("pre_call", crAdr, 11'o0400);
        call = 1; jIn = 11'o1000;
        step();
        chk("call_adr", crAdr, 11'o1000);
        chk("call_depth", stackDepth, 1);
        chk("call_top", stackTop, 11'o0400);
        call = 0; ret = 1; jIn = 11'o0002; dispEn = 1; dispIn = 4'hf;
        step();
        chk("ret_adr", crAdr, 11'o0402);
        chk("ret_depth", stackDepth, 0);
        clr();

        jIn = 11'o0050;
        step(); chk("pre_force", crAdr, 11'o0050);
        force1777 = 1; ret = 1; dramEn = 1; dramJ = 11'o0007; jIn = 11'o0;
        step();
        chk("force_adr", crAdr, 11'o1777);
        chk("force_top", stackTop, 11'o0050);
        chk("force_depth", stackDepth, 1);
        chk("force_trap", trapTaken, 1);
        clr(); advance = 0;
        step();
        chk("trap_pulse_end", trapTaken, 0);
        chk("force_hold", crAdr, 11'o1777);
        advance = 1; ret = 1;
        step();
        chk("trap_ret_adr", crAdr, 11'o0050);
        chk("trap_ret_depth", stackDepth, 0);
        chk("trap_still_low", trapTaken, 0);
        clr();

        for (int i = 0; i < 17; i++) begin
            call = 1; jIn = 11'(11'o0100 + i);
            step();
            if (i == 15) begin
                chk("full_depth", stackDepth, 16);
                chk("full_err", stackErr, 0);
                chk("full_top", stackTop, 11'o0116);
            end
        end
        chk("ovf_depth", stackDepth, 16);
        chk("ovf_err", stackErr, 1);
        chk("ovf_top", stackTop, 11'o0116);
        chk("ovf_adr", crAdr, 11'o0120);
        clr();
        for (int k = 0; k < 16; k++) begin
            ret = 1; jIn = 11'o0;
            step();
            if (k < 15) chk("drain_adr", crAdr, 11'(11'o0116 - k));
        end
        chk("drain_last_adr", crAdr, 11'o0050);
        chk("drain_depth", stackDepth, 0);
        ret = 1; jIn = 11'o0321;
        step();
        chk("udf_adr", crAdr, 11'o0321);
        chk("udf_depth", stackDepth, 0);
        chk("udf_err", stackErr, 1);
        clr();

        call = 1; jIn = 11'o0010;
        step(); chk("cr_pre_depth", stackDepth, 1);
        call = 1; ret = 1; jIn = 11'o0004;
        step();
        chk("callret_adr", crAdr, 11'o0325);
        chk("callret_depth", stackDepth, 1);
        chk("callret_top", stackTop, 11'o0010);
        clr(); ret = 1; jIn = 11'o0;
        step();
        chk("cr_ret_adr", crAdr, 11'o0010);
        call = 1; ret = 1; jIn = 11'o0003;
        step();
        chk("cr_empty_adr", crAdr, 11'o0003);
        chk("cr_empty_depth", stackDepth, 1);
        chk("cr_empty_top", stackTop, 11'o0010);
        clr();

        for (int i = 0; i < 4; i++) begin
            call = 1; jIn = 11'(11'o0600 + i);
            step();
        end
        chk("d5_depth", stackDepth, 5);
        chk("d5_adr", crAdr, 11'o0603);
        advance = 0;
        for (int i = 0; i < 4; i++) begin
            call = i[0]; ret = ~i[0]; force1777 = i[1]; jIn = 11'o0777;
            step();
            chk("hold_adr", crAdr, 11'o0603);
            chk("hold_depth", stackDepth, 5);
            chk("hold_err", stackErr, 1);
            chk("hold_trap", trapTaken, 0);
        end
        advance = 1; reset = 1; call = 1; force1777 = 0; ret = 0;
        step();
        chk("mid_rst_depth", stackDepth, 0);
        chk("mid_rst_adr", crAdr, 0);
        chk("mid_rst_err", stackErr, 0);
        chk("mid_rst_top", stackTop, 0);
        reset = 0; clr(); jIn = 11'o0077;
        step();
        chk("post_rst_adr", crAdr, 11'o0077);
        chk("post_rst_depth", stackDepth, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
